data_bus_responder: RTL
=======================

Name: data_bus_responder

Overview:
- Target-side memory for the CPU data bus. It answers the cpu core's CS / WR_RD / ADDR / Data_BUS_WRITE requests and drives Data_BUS_READ back.
- Adds programmable wait states and a READY/ERR completion handshake, so the core and benches run against realistic memory latency instead of a constant-driven bus.
- Contains a word-addressed synchronous RAM of DEPTH words mapped at BASE_ADDR.

Parameters:
- DEPTH, 1024, number of 32-bit words; power of two, 16 to 65536.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to DEPTH*4.
- WAIT_STATES, 2, extra cycles inserted before completion; 0 to 15.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- CS  in  1  request valid; CPU holds it high until READY.
- WR_RD  in  1  1 = write, 0 = read; sampled with CS.
- ADDR  in  32  byte address.
- Data_BUS_WRITE  in  32  write data.
- Data_BUS_READ  out  32  read data; valid while READY=1, held afterwards.
- READY  out  1  one-cycle completion pulse.
- ERR  out  1  high together with READY when the access faulted.

Behaviour:
- Reset (RST=0, asynchronous): state=IDLE, Data_BUS_READ=0, READY=0, ERR=0, wait counter=0, captured request cleared. RAM contents are not reset.
- States: IDLE, WAIT, RESP, HOLD.
- IDLE:
  - On a rising edge with CS=1, capture ADDR, WR_RD and Data_BUS_WRITE.
  - Go to WAIT with counter=WAIT_STATES, or straight to RESP if WAIT_STATES=0.
- WAIT:
  - Counter decrements each cycle.
  - When it reaches 0, the next edge performs the RAM access and enters RESP.
- RESP (one cycle):
  - READY=1.
  - Read: Data_BUS_READ = RAM word.
  - Write: RAM is updated on the entry edge and Data_BUS_READ is unchanged.
  - Next state is HOLD if CS=1, else IDLE.
- HOLD: wait for CS=0, then IDLE. A request held high is never re-issued.
- Latency: READY is asserted WAIT_STATES+1 cycles after the capture edge. With WAIT_STATES=0 that is the cycle after capture.
- Fault conditions, checked on the captured address:
  - ADDR[1:0] != 0, or
  - address outside [BASE_ADDR, BASE_ADDR+DEPTH*4-1].
- Fault handling:
  - No RAM write occurs.
  - A faulted read returns Data_BUS_READ=0.
  - ERR=1 during the RESP cycle only. Timing is otherwise identical to a good access.
- Word index = (ADDR - BASE_ADDR) >> 2, truncated to log2(DEPTH) bits after the range check passes.
- Abort: if CS drops during WAIT, return to IDLE on the next edge with no write, no READY and no ERR. A CS drop in the same cycle the counter reaches 0 also aborts.
- Captured values are stable for the whole transaction. Changes on ADDR or data after capture are ignored.
- Reset mid-transaction: everything returns to the reset state immediately; a pending write is lost.
- Wait-state counter is 4 bits and never wraps below 0.

Optional Feature:
- Macro: DATA_BUS_PARITY_EN.
- Defined:
  - RAM width becomes 33 bits; bit 32 holds the even parity of the write data.
  - A read recomputes parity and sets ERR=1 in RESP on mismatch, while still returning the stored data.
  - An extra input, PAR_INJECT (1 bit), inverts the stored parity bit on writes, for fault testing.
- Not defined: 32-bit RAM, no PAR_INJECT port, and ERR reports only address faults.

Decomposition:
- Shared package data_bus_pkg holds:
  - state encoding enum (IDLE=2'd0, WAIT=2'd1, RESP=2'd2, HOLD=2'd3)
  - WR/RD encoding constants
  - bus width constant (32)
  - fault read value constant (0)
- One sub-module, dmem_ram: single-port synchronous RAM with write enable and one-cycle registered read, width set by parameter (32 or 33).
- The FSM, counter, range check and parity logic live in the top.

Test Plan:
- WAIT_STATES=2: write 32'hCAFE_0001 to BASE+8, then read BASE+8 → each READY comes 3 cycles after capture; the read returns 32'hCAFE_0001 with ERR=0.
- WAIT_STATES=0: back-to-back reads of BASE+0 and BASE+4 with CS dropped for one cycle between them → READY the cycle after each capture; there is no second READY while CS is held in HOLD.
- Read ADDR=BASE+2 (misaligned) and ADDR=BASE+DEPTH*4 (out of range) → READY and ERR together, data=0; a write to the out-of-range address leaves BASE+0 unchanged.
- Start a write of 32'h1234_5678 to BASE+12 and drop CS in the first WAIT cycle → no READY; a later read of BASE+12 returns the old value.
- Pull RST low during WAIT of a write → outputs are 0 immediately; after release, a read returns the pre-write data and the FSM is back in IDLE.
- With DATA_BUS_PARITY_EN: write with PAR_INJECT=1, then read → ERR=1 and the stored data is still returned.

Source files
------------

// File: rtl/data_bus_pkg.sv
// Shared definitions for the CPU data-bus responder: FSM states, bus encodings and widths.
package data_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2,
    HOLD = 2'd3
  } bus_state_t;

  localparam int BUS_W = 32;

  localparam logic BUS_WR = 1'b1;
  localparam logic BUS_RD = 1'b0;

  localparam logic [BUS_W-1:0] FAULT_RDATA = '0;

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous RAM with a write enable and a one-cycle registered read.
module dmem_ram #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately not reset so this maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_bus_responder.sv
// Target-side data memory with programmable wait states and a READY/ERR handshake.
// Optional DATA_BUS_PARITY_EN adds a stored even-parity bit and the PAR_INJECT fault input.
module data_bus_responder
  import data_bus_pkg::*;
#(
  parameter int          DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CS,
  input  logic             WR_RD,
  input  logic [BUS_W-1:0] ADDR,
  input  logic [BUS_W-1:0] Data_BUS_WRITE,
`ifdef DATA_BUS_PARITY_EN
  input  logic             PAR_INJECT,
`endif
  output logic [BUS_W-1:0] Data_BUS_READ,
  output logic             READY,
  output logic             ERR
);

  localparam int          AW            = $clog2(DEPTH);
  localparam logic [31:0] RANGE_BYTES   = 32'(DEPTH) << 2;
  localparam logic [3:0]  WAIT_CNT_INIT = 4'(WAIT_STATES);
`ifdef DATA_BUS_PARITY_EN
  localparam int          RAM_W         = BUS_W + 1;
`else
  localparam int          RAM_W         = BUS_W;
`endif

  bus_state_t       state;
  logic [3:0]       wait_cnt;
  logic [BUS_W-1:0] cap_addr;
  logic [BUS_W-1:0] cap_wdata;
  logic             cap_wr;
  logic [BUS_W-1:0] read_hold;
  logic             ready_q;
  logic             err_q;
  logic             rd_ok;

  logic [BUS_W-1:0] offset;
  logic             addr_fault;
  logic             access;
  logic             ram_we;
  logic             ram_re;
  logic [AW-1:0]    word_idx;
  logic [RAM_W-1:0] ram_wdata;
  logic [RAM_W-1:0] ram_q;
  logic             par_err;

  // An address below BASE_ADDR wraps to a huge offset, so one compare covers both ends.
  assign offset     = cap_addr - BASE_ADDR;
  assign addr_fault = (cap_addr[1:0] != 2'b00) || (offset >= RANGE_BYTES);
  assign word_idx   = offset[AW+1:2];

  assign access = (state == WAIT) && CS && (wait_cnt == 4'd0);
  assign ram_we = access && (cap_wr == BUS_WR) && !addr_fault;
  assign ram_re = access && (cap_wr == BUS_RD) && !addr_fault;

`ifdef DATA_BUS_PARITY_EN
  logic cap_inj;

  assign ram_wdata = {(^cap_wdata) ^ cap_inj, cap_wdata};
  assign par_err   = rd_ok && (^ram_q);
`else
  assign ram_wdata = cap_wdata;
  assign par_err   = 1'b0;
`endif

  dmem_ram #(
    .DEPTH (DEPTH),
    .WIDTH (RAM_W)
  ) u_ram (
    .clk   (CLK),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (word_idx),
    .wdata (ram_wdata),
    .rdata (ram_q)
  );

  // Read data comes straight from the RAM during RESP and is latched for the hold phase.
  assign Data_BUS_READ = rd_ok ? ram_q[BUS_W-1:0] : read_hold;
  assign READY         = ready_q;
  assign ERR           = err_q | par_err;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      wait_cnt  <= 4'd0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_wr    <= 1'b0;
`ifdef DATA_BUS_PARITY_EN
      cap_inj   <= 1'b0;
`endif
      read_hold <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      rd_ok     <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (CS) begin
            cap_addr  <= ADDR;
            cap_wr    <= WR_RD;
            cap_wdata <= Data_BUS_WRITE;
`ifdef DATA_BUS_PARITY_EN
            cap_inj   <= PAR_INJECT;
`endif
            wait_cnt  <= WAIT_CNT_INIT;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (!CS) begin
            wait_cnt <= 4'd0;
            state    <= IDLE;
          end else if (wait_cnt == 4'd0) begin
            ready_q <= 1'b1;
            err_q   <= addr_fault;
            rd_ok   <= (cap_wr == BUS_RD) && !addr_fault;
            if ((cap_wr == BUS_RD) && addr_fault) begin
              read_hold <= FAULT_RDATA;
            end
            state   <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        RESP: begin
          if (rd_ok) begin
            read_hold <= ram_q[BUS_W-1:0];
          end
          rd_ok <= 1'b0;
          state <= CS ? HOLD : IDLE;
        end
        HOLD: begin
          if (!CS) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
